rom_load_sequencer: RTL and testbench
=====================================

Name: rom_load_sequencer

Overview:
- Sits between hps_io's ioctl download port and the game core's dn_* ROM-load interface.
- Decodes the flat download stream into three ROM regions: program, graphics and sound.
- Buffers writes in a 2-entry queue and forwards them with a valid/ready handshake, so slow ROM storage can back-pressure the loader.
- Owns core reset sequencing: holds the core in reset during a download, validates the image size, and releases reset a fixed delay after a good load.

Parameters:
- PROG_TOP, 16'h6000, first address past the program region (program = 0..PROG_TOP-1).
- GFX_TOP, 16'h8000, first address past the graphics region.
- SND_TOP, 17'h0A000, first address past the sound region; this is also the required image size in bytes.
- POST_RESET_CYCLES, 16'd1024, clk_sys cycles core_reset stays high after the queue drains.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download in progress (level).
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- dn_wr  out  1  write valid.
- dn_ready  in  1  sink accepts the write this cycle.
- dn_addr  out  16  region-local address (ioctl_addr minus region base).
- dn_data  out  8  write data.
- dn_region  out  2  region select: 0 = program, 1 = graphics, 2 = sound.
- core_reset  out  1  reset to the game core.
- busy  out  1  queue non-empty, or state is LOAD or DRAIN.
- load_done  out  1  sticky: last load was valid.
- size_err  out  1  sticky: out-of-range address seen, or byte count != SND_TOP.
- overflow  out  1  sticky: a write was dropped because the queue was full.

Behaviour:
- Reset values, applied the cycle after reset is sampled high:
  - state = IDLE; queue empty; byte counter = 0; hold counter = 0.
  - dn_wr = 0, dn_addr = 0, dn_data = 0, dn_region = 0.
  - core_reset = 1, busy = 0, load_done = 0, size_err = 0, overflow = 0.
  - Reset mid-load discards all queued writes; no dn_wr is issued after it.
- States: IDLE, LOAD, DRAIN, HOLD, RUN.
  - IDLE/HOLD/RUN with ioctl_download = 1 → LOAD. On entry:
    - core_reset = 1 (registered; high the cycle after ioctl_download is sampled);
    - load_done, size_err and overflow cleared;
    - byte counter cleared.
  - LOAD: accept writes. ioctl_download = 0 → DRAIN.
  - DRAIN: when the queue is empty and no dn_wr is pending, the size check runs:
    - byte counter == SND_TOP and size_err clear → HOLD, hold counter = POST_RESET_CYCLES;
    - otherwise → IDLE, size_err = 1, core_reset stays 1.
    - ioctl_download is ignored while in DRAIN.
  - HOLD: hold counter decrements once per cycle. At 0 → RUN, with core_reset = 0 and load_done = 1 in the same registered update.
    - core_reset therefore falls exactly POST_RESET_CYCLES+1 cycles after DRAIN exits.
  - RUN: core_reset = 0 until the next download.
- Address decode, applied when ioctl_wr = 1 in LOAD:
  - ioctl_addr[24:17] != 0 or addr >= SND_TOP: write dropped, size_err = 1, not counted.
  - addr < PROG_TOP: region 0, local = addr.
  - addr < GFX_TOP: region 1, local = addr - PROG_TOP.
  - otherwise: region 2, local = addr - GFX_TOP.
  - Local address is truncated to 16 bits.
  - ioctl_wr outside LOAD is ignored.
- Queue: 2 entries, FIFO order, each entry {region, addr, data}.
  - Head drives dn_*. dn_wr = queue non-empty.
  - Head pops when dn_wr & dn_ready. dn_addr/dn_data/dn_region are held stable while dn_wr & !dn_ready.
  - A counted write enqueued into an empty queue shows on dn_wr the next cycle (1-cycle latency).
  - Enqueue and pop in the same cycle on a full queue: accepted, occupancy stays 2.
  - Enqueue on a full queue with no pop: byte dropped, overflow = 1, byte not counted.
  - The counted byte counter (17 bits, saturating) increments only on enqueue.
- dn_ready is sampled only while dn_wr = 1.

Test Plan:
- Full load of 0x0000..0x9FFF, one ioctl_wr every 4 cycles, dn_ready = 1 → 40960 dn_wr handshakes, in order.
  - Addr 0x5FFF → region 0 / 0x5FFF; 0x6000 → region 1 / 0x0000; 0x8000 → region 2 / 0x0000.
  - After 1024+1 HOLD cycles: core_reset = 0, load_done = 1, size_err = 0.
- Back-pressure: dn_ready = 0 for 10 cycles, writes to 0x10, 0x11, 0x12 on consecutive cycles → 0x10 and 0x11 queued, 0x12 dropped, overflow = 1.
  - When dn_ready = 1: exactly two handshakes, 0x10 then 0x11, data unchanged while stalled.
- Short image (0x0000..0x8FFF) → DRAIN → IDLE; size_err = 1, load_done = 0, core_reset stays 1.
- Write to 0x0A000 and to 0x1_0000 during LOAD → no dn_wr for either, size_err = 1; otherwise-full image still ends in IDLE.
- Reset asserted mid-load with 2 entries queued and dn_ready = 0 → next cycle dn_wr = 0, busy = 0, all outputs at reset values, state IDLE.
- From RUN, raise ioctl_download → core_reset = 1 one cycle later, load_done = 0.
  - A complete reload then releases core_reset again after POST_RESET_CYCLES.

Source files
------------

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//
// Bridges the hps_io ioctl download port to the game core's dn_* ROM-load
// interface. The flat download stream is split into three ROM regions
// (program, graphics, sound). Accepted bytes are buffered in a 2-entry FIFO
// and forwarded to the ROM storage with a valid/ready handshake. The block
// also owns the core reset: the core is held in reset while a download is
// running, the image size is validated, and reset is released a fixed number
// of cycles after a good load has fully drained.
//
// Handshake (dn_*): dn_wr is the valid, dn_ready the ready. A write transfers
// on a rising clk_sys edge where dn_wr && dn_ready. While dn_wr is high and
// dn_ready is low, dn_addr/dn_data/dn_region are held stable. dn_ready is
// only meaningful while dn_wr is high.
//
// Ports:
//   clk_sys         system clock, rising edge
//   reset           synchronous, active-high
//   ioctl_download  download in progress (level)
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address (25 bits)
//   ioctl_dout      byte data
//   dn_wr           write valid (FIFO non-empty)
//   dn_ready        sink accepts the write this cycle
//   dn_addr         region-local address
//   dn_data         write data
//   dn_region       0 = program, 1 = graphics, 2 = sound
//   core_reset      reset to the game core
//   busy            FIFO non-empty, or loading / draining
//   load_done       sticky: last load was valid
//   size_err        sticky: out-of-range address or wrong byte count
//   overflow        sticky: a byte was dropped because the FIFO was full
//   dbg_state       current FSM state (debug observation)

module rom_load_sequencer #(
  parameter logic [15:0] PROG_TOP          = 16'h6000,
  parameter logic [15:0] GFX_TOP           = 16'h8000,
  parameter logic [16:0] SND_TOP           = 17'h0A000,
  parameter logic [15:0] POST_RESET_CYCLES = 16'd1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        dn_wr,
  input  logic        dn_ready,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [1:0]  dn_region,
  output logic        core_reset,
  output logic        busy,
  output logic        load_done,
  output logic        size_err,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0]  region;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,      state_d;
  entry_t      head_q,       head_d;     // FIFO slot 0, drives dn_*
  entry_t      tail_q,       tail_d;     // FIFO slot 1
  logic [1:0]  fifo_cnt_q,   fifo_cnt_d;
  logic [16:0] byte_cnt_q,   byte_cnt_d;
  logic [15:0] hold_cnt_q,   hold_cnt_d;
  logic        core_reset_q, core_reset_d;
  logic        load_done_q,  load_done_d;
  logic        size_err_q,   size_err_d;
  logic        overflow_q,   overflow_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [16:0] addr_lo;
  logic        addr_ok;
  logic [16:0] off_prog;
  logic [16:0] off_gfx;
  entry_t      new_ent;

  assign addr_lo  = ioctl_addr[16:0];
  // Anything at or beyond the sound top, including addresses with upper
  // bits set that would otherwise alias into the image, is rejected.
  assign addr_ok  = (ioctl_addr[24:17] == 8'd0) && (addr_lo < SND_TOP);
  assign off_prog = addr_lo - {1'b0, PROG_TOP};
  assign off_gfx  = addr_lo - {1'b0, GFX_TOP};

  always_comb begin
    new_ent.data = ioctl_dout;
    if (addr_lo < {1'b0, PROG_TOP}) begin
      new_ent.region = 2'd0;
      new_ent.addr   = addr_lo[15:0];
    end else if (addr_lo < {1'b0, GFX_TOP}) begin
      new_ent.region = 2'd1;
      new_ent.addr   = off_prog[15:0];
    end else begin
      new_ent.region = 2'd2;
      new_ent.addr   = off_gfx[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic wr_req;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop_range;
  logic drop_full;

  assign dn_wr      = (fifo_cnt_q != 2'd0);
  assign fifo_full  = (fifo_cnt_q == 2'd2);
  assign pop        = dn_wr && dn_ready;
  assign wr_req     = (state_q == ST_LOAD) && ioctl_wr;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push       = wr_req && addr_ok && (!fifo_full || pop);
  assign drop_range = wr_req && !addr_ok;
  assign drop_full  = wr_req && addr_ok && fifo_full && !pop;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) begin
          head_d = new_ent;
        end else begin
          tail_d = new_ent;
        end
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new byte lands behind whatever stays.
        if (fifo_cnt_q == 2'd1) begin
          head_d = new_ent;
        end else begin
          head_d = tail_q;
          tail_d = new_ent;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    core_reset_d = core_reset_q;
    load_done_d  = load_done_q;
    size_err_d   = size_err_q | drop_range;
    overflow_d   = overflow_q | drop_full;
    byte_cnt_d   = byte_cnt_q;
    if (push && (byte_cnt_q != 17'h1FFFF)) begin
      byte_cnt_d = byte_cnt_q + 17'd1;
    end

    case (state_q)
      ST_IDLE, ST_HOLD, ST_RUN: begin
        if (ioctl_download) begin
          // A new download always restarts from a clean slate, even from HOLD.
          state_d      = ST_LOAD;
          core_reset_d = 1'b1;
          load_done_d  = 1'b0;
          size_err_d   = 1'b0;
          overflow_d   = 1'b0;
          byte_cnt_d   = 17'd0;
        end else if (state_q == ST_HOLD) begin
          if (hold_cnt_q == 16'd0) begin
            state_d      = ST_RUN;
            core_reset_d = 1'b0;
            load_done_d  = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q - 16'd1;
          end
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The size check waits until every accepted byte has been handed off,
        // so the core never leaves reset with ROM writes still in flight.
        if (fifo_cnt_q == 2'd0) begin
          if ((byte_cnt_q == SND_TOP) && !size_err_q) begin
            state_d    = ST_HOLD;
            hold_cnt_d = POST_RESET_CYCLES;
          end else begin
            state_d      = ST_IDLE;
            size_err_d   = 1'b1;
            core_reset_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      fifo_cnt_q   <= 2'd0;
      byte_cnt_q   <= 17'd0;
      hold_cnt_q   <= 16'd0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      size_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      fifo_cnt_q   <= fifo_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      size_err_q   <= size_err_d;
      overflow_q   <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dn_addr    = head_q.addr;
  assign dn_data    = head_q.data;
  assign dn_region  = head_q.region;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign size_err   = size_err_q;
  assign overflow   = overflow_q;
  assign busy       = dn_wr || (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Testbench for rom_load_sequencer. The image map is scaled down so that
// several complete loads fit in a short run; the region boundaries keep the
// same shape as the production map.
module tb_rom_load_sequencer;

  localparam logic [15:0] PROG_TOP = 16'h0600;
  localparam logic [15:0] GFX_TOP  = 16'h0800;
  localparam logic [16:0] SND_TOP  = 17'h00A00;
  localparam logic [15:0] POST     = 16'd100;
  localparam int          W        = 26;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        dn_ready = 1'b1;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [1:0]  dn_region;
  logic        core_reset;
  logic        busy;
  logic        load_done;
  logic        size_err;
  logic        overflow;
  logic [2:0]  dbg_state;

  always #5 clk_sys = ~clk_sys;

  rom_load_sequencer #(
    .PROG_TOP         (PROG_TOP),
    .GFX_TOP          (GFX_TOP),
    .SND_TOP          (SND_TOP),
    .POST_RESET_CYCLES(POST)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .dn_wr         (dn_wr),
    .dn_ready      (dn_ready),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_region     (dn_region),
    .core_reset    (core_reset),
    .busy          (busy),
    .load_done     (load_done),
    .size_err      (size_err),
    .overflow      (overflow),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int  cyc        = 0;
  int  m_occ      = 0;
  int  m_count    = 0;
  int  m_exit_cyc = 0;
  int  hs_count   = 0;
  bit  m_loading  = 0;
  bit  m_drain    = 0;
  bit  m_exit_flag = 0;
  bit  m_size_err = 0;
  bit  m_overflow = 0;
  bit  mon_en     = 0;
  bit  rand_ready = 0;

  function automatic logic [W-1:0] model_entry(input logic [24:0] a, input logic [7:0] d);
    int ai;
    ai = int'(a);
    if (ai < int'(PROG_TOP)) return {2'd0, 16'(ai), d};
    if (ai < int'(GFX_TOP))  return {2'd1, 16'(ai - int'(PROG_TOP)), d};
    return {2'd2, 16'(ai - int'(GFX_TOP)), d};
  endfunction

  // Cycle-level view of the load: which bytes get through, how many are
  // waiting, and when the drain finishes.
  initial forever begin : model
    bit m_pop;
    bit m_push;
    int occ_before;
    @(posedge clk_sys);
    cyc++;
    if (reset) begin
      m_occ = 0; m_loading = 0; m_drain = 0; m_exit_flag = 0;
      m_size_err = 0; m_overflow = 0; m_count = 0;
      exp_q.delete();
    end else begin
      occ_before = m_occ;
      m_pop  = (m_occ != 0) && (dn_ready == 1'b1);
      m_push = 0;
      if (m_loading && ioctl_wr) begin
        if (int'(ioctl_addr) >= int'(SND_TOP)) m_size_err = 1;
        else if (m_occ == 2 && !m_pop) m_overflow = 1;
        else begin
          m_push = 1;
          exp_q.push_back(model_entry(ioctl_addr, ioctl_dout));
          m_count++;
        end
      end
      m_occ = m_occ + int'(m_push) - int'(m_pop);
      if (m_drain) begin
        if (occ_before == 0) begin
          m_drain = 0;
          m_exit_flag = 1;
          m_exit_cyc = cyc;
          if (!(m_count == int'(SND_TOP) && !m_size_err)) m_size_err = 1;
        end
      end else if (m_loading) begin
        if (!ioctl_download) begin
          m_loading = 0;
          m_drain = 1;
        end
      end else if (ioctl_download) begin
        m_loading = 1; m_count = 0; m_size_err = 0; m_overflow = 0; m_exit_flag = 0;
      end
    end
  end

  // Scoreboard: every handshake must match the oldest expected write, and the
  // head must match it while stalled too.
  initial forever begin : monitor
    @(negedge clk_sys);
    if (mon_en) begin
      check_val("dn_wr", dn_wr, 32'(m_occ != 0));
      check_val("busy", busy, 32'((m_occ != 0) || m_loading || m_drain));
      check_val("size_err_track", size_err, 32'(m_size_err));
      check_val("overflow_track", overflow, 32'(m_overflow));
      if (dn_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_val("dn_unexpected_wr", dn_wr, 0);
        end else begin
          check_val("dn_entry", {dn_region, dn_addr, dn_data}, exp_q[0]);
          if (dn_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
    end
  end

  initial forever begin : ready_gen
    @(posedge clk_sys);
    #2;
    if (rand_ready) dn_ready = 1'($urandom_range(0, 1));
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (callers sit 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_load();
    ioctl_download = 1'b1;
    tick(1);
    check_val("load_core_reset", core_reset, 1);
    check_val("load_done_clr", load_done, 0);
    check_val("load_state", dbg_state, ST_LOAD);
  endtask

  task automatic write_image(input int top, input int gap_max);
    for (int a = 0; a < top; a++) begin
      write_byte(25'(a), 8'($urandom));
      if (gap_max > 0) tick($urandom_range(0, gap_max));
    end
  endtask

  task automatic finish_load(input bit expect_good);
    int guard;
    ioctl_download = 1'b0;
    guard = 0;
    while (!m_exit_flag && guard < 500) begin
      tick(1);
      guard++;
    end
    check_val("drain_exit", 32'(m_exit_flag), 1);
    if (expect_good) begin
      check_val("hold_state", dbg_state, ST_HOLD);
      check_val("hold_core_reset", core_reset, 1);
      check_val("hold_load_done", load_done, 0);
      while (cyc < m_exit_cyc + int'(POST)) tick(1);
      check_val("hold_last_cycle", core_reset, 1);
      tick(1);
      check_val("release_core_reset", core_reset, 0);
      check_val("release_load_done", load_done, 1);
      check_val("release_size_err", size_err, 0);
      check_val("release_state", dbg_state, ST_RUN);
    end else begin
      check_val("bad_state", dbg_state, ST_IDLE);
      check_val("bad_core_reset", core_reset, 1);
      check_val("bad_load_done", load_done, 0);
      check_val("bad_size_err", size_err, 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_dn_wr"}, dn_wr, 0);
    check_val({tag, "_dn_addr"}, dn_addr, 0);
    check_val({tag, "_dn_data"}, dn_data, 0);
    check_val({tag, "_dn_region"}, dn_region, 0);
    check_val({tag, "_core_reset"}, core_reset, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_load_done"}, load_done, 0);
    check_val({tag, "_size_err"}, size_err, 0);
    check_val({tag, "_overflow"}, overflow, 0);
    check_val({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int hs0;
    tick(2);
    check_reset_values("rst");
    mon_en = 1;
    reset = 1'b0;
    tick(1);

    // Full good load with dn_ready held high.
    hs0 = hs_count;
    start_load();
    write_image(int'(SND_TOP), 1);
    check_val("full_core_reset", core_reset, 1);
    finish_load(1'b1);
    check_val("full_handshakes", hs_count - hs0, int'(SND_TOP));

    // Strobes outside a download are ignored.
    write_byte(25'h20, 8'hAA);
    tick(3);
    check_val("run_core_reset", core_reset, 0);

    // Reload from RUN.
    start_load();
    write_image(int'(SND_TOP), 2);
    finish_load(1'b1);

    // Back-pressure: two bytes queue, the third is dropped.
    start_load();
    dn_ready = 1'b0;
    write_byte(25'h10, 8'h5A);
    write_byte(25'h11, 8'hC3);
    write_byte(25'h12, 8'h7E);
    tick(7);
    check_val("bp_overflow", overflow, 1);
    check_val("bp_dn_wr", dn_wr, 1);
    check_val("bp_head", {dn_region, dn_addr, dn_data}, {2'd0, 16'h0010, 8'h5A});
    hs0 = hs_count;
    dn_ready = 1'b1;
    tick(4);
    check_val("bp_handshakes", hs_count - hs0, 2);
    finish_load(1'b0);

    // Short image under random back-pressure.
    start_load();
    rand_ready = 1;
    write_image(int'(SND_TOP) * 9 / 10, 2);
    rand_ready = 0;
    dn_ready = 1'b1;
    finish_load(1'b0);

    // Out-of-range writes spoil an otherwise full image.
    start_load();
    write_byte(25'(SND_TOP), 8'h11);
    write_byte(25'h1_0000, 8'h22);
    write_byte(25'h2_0005, 8'h33);
    check_val("oor_size_err", size_err, 1);
    write_image(int'(SND_TOP), 0);
    finish_load(1'b0);

    // Reset with two entries stalled in the queue.
    start_load();
    dn_ready = 1'b0;
    write_byte(25'h30, 8'($urandom_range(1, 255)));
    write_byte(25'h631, 8'($urandom_range(1, 255)));
    tick(1);
    check_val("mid_dn_wr", dn_wr, 1);
    reset = 1'b1;
    tick(1);
    check_reset_values("mid_rst");
    reset = 1'b0;
    ioctl_download = 1'b0;
    hs0 = hs_count;
    dn_ready = 1'b1;
    tick(3);
    check_val("post_rst_dn_wr", dn_wr, 0);
    check_val("post_rst_handshakes", hs_count - hs0, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
